win_accum: RTL and testbench
============================

WIN_ACCUM -- requirements
Module: win_accum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the input sample width.
REQ-002 The block SHALL have parameter NSAMP, default 8, giving samples per window; legal range 2..256.
REQ-003 The block SHALL have localparam ACC_W = WIDTH + $clog2(NSAMP), giving the sum width.
REQ-004 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port c_in  input  WIDTH: unsigned sample from the upstream two-stage function pipeline.
REQ-007 Port in_valid  input  1: c_in holds a valid sample.
REQ-008 Port in_ready  output  1: block accepts c_in this cycle.
REQ-009 Port sum_out  output  ACC_W: unsigned sum of the completed window.
REQ-010 Port out_valid  output  1: sum_out holds a completed window.
REQ-011 Port out_ready  input  1: consumer takes sum_out this cycle.

Function
REQ-012 The block SHALL accept a sample when in_valid && in_ready on a rising clk edge, and only then.
REQ-013 The block SHALL implement a two-state FSM: ACC (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-014 In ACC, each accepted sample SHALL add to the accumulator and increment a sample counter (0..NSAMP-1).
REQ-015 When the NSAMP-th sample is accepted, the block SHALL load sum_out with the full sum including that sample, clear the accumulator and counter, and enter DONE on the same edge; out_valid is therefore high in the cycle after the last sample (latency 1).
REQ-016 In DONE, sum_out SHALL stay stable, and out_valid SHALL stay high, until out_valid && out_ready on a rising edge; that edge SHALL return the FSM to ACC.
REQ-017 in_valid low cycles (gaps) SHALL leave the accumulator, counter and state unchanged.
REQ-018 Sums SHALL be zero-extended to ACC_W; no overflow is possible; no saturation logic.
REQ-019 in_ready and out_valid SHALL be driven directly from state registers, with no combinational path from any input.
REQ-020 out_ready while in ACC SHALL be ignored.

Reset
REQ-021 rst high SHALL force: state=ACC, accumulator=0, counter=0, sum_out=0, out_valid=0, in_ready=1 on the next edge.
REQ-022 rst SHALL take priority over any simultaneous sample acceptance or output handshake.
REQ-023 rst mid-window or in DONE SHALL discard the partial sum or the pending result.

Configuration
REQ-024 With macro WIN_ACCUM_MINMAX_EN defined, the block SHALL add outputs max_out and min_out (WIDTH each), giving the largest and smallest sample of the completed window.
REQ-025 max_out and min_out SHALL be valid and held under the same rules as sum_out; their reset value is 0.
REQ-026 Without WIN_ACCUM_MINMAX_EN, these ports and their logic SHALL be absent.

Structure
REQ-027 Package win_accum_pkg SHALL hold the FSM state enum (ACC, DONE) and the default constants (WIDTH=16, NSAMP=8).
REQ-028 The min/max tracking SHALL be a sub-module minmax_trk, instantiated only under WIN_ACCUM_MINMAX_EN.

Verification (WIDTH=16, NSAMP=4, 10 ns clock)
REQ-029 Basic window: samples 12, 30, 150, 0 on consecutive cycles -> out_valid high one cycle after the 4th sample; sum_out=192.
REQ-030 Width: four samples of 0xFFFF -> sum_out=0x3FFFC (ACC_W=18).
REQ-031 Backpressure: out_ready low for 3 cycles after the window completes -> out_valid held, sum_out stable, in_ready=0, extra in_valid samples not accepted; out_ready high -> in_ready=1 next cycle.
REQ-032 Gaps: samples 1, 2, 3, 4 with in_valid low 2 cycles between each -> sum_out=10; no early out_valid.
REQ-033 Reset mid-window: accept 7, 9, then pulse rst, then samples 1, 2, 3, 4 -> sum_out=10.
REQ-034 MINMAX_EN: samples 12, 30, 150, 0 -> max_out=150, min_out=0, sum_out=192.

Source files
------------

// File: rtl/win_accum_pkg.sv
// Shared types and default constants for the windowed accumulator.
// Imported by win_accum and minmax_trk.
package win_accum_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_NSAMP = 8;

   typedef enum logic {
      ACC  = 1'b0,
      DONE = 1'b1
   } state_e;

endpackage

// File: rtl/minmax_trk.sv
// Running min/max tracker for one window of unsigned samples.
// The window result is registered on the edge that accepts the last sample.
module minmax_trk
   import win_accum_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sample_i,
   input  logic             accept_i,
   input  logic             first_i,
   input  logic             last_i,
   output logic [WIDTH-1:0] max_o,
   output logic [WIDTH-1:0] min_o
);

   logic [WIDTH-1:0] run_max_q, run_max_d;
   logic [WIDTH-1:0] run_min_q, run_min_d;
   logic [WIDTH-1:0] max_q;
   logic [WIDTH-1:0] min_q;

   // The first sample of a window seeds both extremes, so stale values never leak in.
   always_comb begin
      run_max_d = run_max_q;
      run_min_d = run_min_q;
      if (first_i) begin
         run_max_d = sample_i;
         run_min_d = sample_i;
      end else begin
         if (sample_i > run_max_q) run_max_d = sample_i;
         if (sample_i < run_min_q) run_min_d = sample_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_max_q <= '0;
         run_min_q <= '0;
         max_q     <= '0;
         min_q     <= '0;
      end else if (accept_i) begin
         run_max_q <= run_max_d;
         run_min_q <= run_min_d;
         if (last_i) begin
            max_q <= run_max_d;
            min_q <= run_min_d;
         end
      end
   end

   assign max_o = max_q;
   assign min_o = min_q;

endmodule

// File: rtl/win_accum.sv
// Sums NSAMP unsigned samples per window and presents the sum with a valid/ready handshake.
// Optional WIN_ACCUM_MINMAX_EN adds per-window max_out/min_out.
module win_accum
   import win_accum_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int NSAMP = DEF_NSAMP,
   localparam int ACC_W = WIDTH + $clog2(NSAMP)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] c_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [ACC_W-1:0] sum_out,
   output logic             out_valid,
   input  logic             out_ready
`ifdef WIN_ACCUM_MINMAX_EN
   ,
   output logic [WIDTH-1:0] max_out,
   output logic [WIDTH-1:0] min_out
`endif
);

   localparam int               CNT_W    = $clog2(NSAMP);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSAMP - 1);

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] sum_q, sum_d;

   logic             accept;
   logic             last_sample;
   logic [ACC_W-1:0] acc_plus;

   assign accept      = in_valid && (state_q == ACC);
   assign last_sample = accept && (cnt_q == CNT_LAST);
   assign acc_plus    = acc_q + ACC_W'(c_in);

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      unique case (state_q)
         ACC: begin
            if (accept) begin
               if (last_sample) begin
                  sum_d   = acc_plus;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  acc_d = acc_plus;
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         DONE: begin
            if (out_ready) state_d = ACC;
         end
         default: state_d = ACC;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACC;
         acc_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
      end
   end

   // Handshake outputs decode only the state register, never an input.
   assign in_ready  = (state_q == ACC);
   assign out_valid = (state_q == DONE);
   assign sum_out   = sum_q;

`ifdef WIN_ACCUM_MINMAX_EN
   minmax_trk #(
      .WIDTH (WIDTH)
   ) u_minmax (
      .clk      (clk),
      .rst      (rst),
      .sample_i (c_in),
      .accept_i (accept),
      .first_i  (cnt_q == '0),
      .last_i   (last_sample),
      .max_o    (max_out),
      .min_o    (min_out)
   );
`endif

endmodule

// File: tb/tb_win_accum.sv
// Scoreboard bench for win_accum (WIDTH=16, NSAMP=4): stimulus pushes expected windows,
// a negedge monitor pops and compares on every output handshake.
module tb_win_accum;

   localparam int WIDTH = 16;
   localparam int NSAMP = 4;
   localparam int ACC_W = 18;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] c_in;
   logic             in_valid;
   logic             in_ready;
   logic [ACC_W-1:0] sum_out;
   logic             out_valid;
   logic             out_ready;
`ifdef WIN_ACCUM_MINMAX_EN
   logic [WIDTH-1:0] max_out;
   logic [WIDTH-1:0] min_out;
`endif

   typedef struct packed {
      logic [ACC_W-1:0] sum;
      logic [WIDTH-1:0] mx;
      logic [WIDTH-1:0] mn;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   win_accum #(
      .WIDTH (WIDTH),
      .NSAMP (NSAMP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .c_in      (c_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum_out   (sum_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef WIN_ACCUM_MINMAX_EN
      ,
      .max_out   (max_out),
      .min_out   (min_out)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input int s, input int mx, input int mn);
      exp_t e;
      e.sum = ACC_W'(s);
      e.mx  = WIDTH'(mx);
      e.mn  = WIDTH'(mn);
      return e;
   endfunction

   // Monitor: a handshake completes at the next rising edge whenever both are high here.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", out_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("sum_out", sum_out, e.sum);
`ifdef WIN_ACCUM_MINMAX_EN
            check("max_out", max_out, e.mx);
            check("min_out", min_out, e.mn);
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [WIDTH-1:0] v);
      c_in     = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      c_in      = '0;
      out_ready = 1'b1;
      tick();
      tick();
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_sum_out", sum_out, 0);
      rst = 1'b0;
      tick();

      // Basic window, back-to-back samples.
      send(16'd12);
      send(16'd30);
      send(16'd150);
      exp_q.push_back(mk(192, 150, 0));
      send(16'd0);
      check("basic_latency_valid", out_valid, 1'b1);
      check("basic_in_ready_low", in_ready, 1'b0);
      tick();
      check("basic_back_to_acc", in_ready, 1'b1);

      // Full-scale samples exercise the widened sum.
      send(16'hFFFF);
      send(16'hFFFF);
      send(16'hFFFF);
      exp_q.push_back(mk(32'h3FFFC, 16'hFFFF, 16'hFFFF));
      send(16'hFFFF);
      tick();

      // Backpressure: result held three cycles while extra samples are offered.
      out_ready = 1'b0;
      send(16'd5);
      send(16'd6);
      send(16'd7);
      exp_q.push_back(mk(26, 8, 5));
      send(16'd8);
      for (int i = 0; i < 3; i++) begin
         c_in     = 16'd1000;
         in_valid = 1'b1;
         check("bp_out_valid_held", out_valid, 1'b1);
         check("bp_in_ready_low", in_ready, 1'b0);
         check("bp_sum_stable", sum_out, 26);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release_in_ready", in_ready, 1'b1);
      check("bp_release_out_valid", out_valid, 1'b0);

      // Gaps between samples; a preceding stray 1000 would corrupt this sum.
      send(16'd1);
      repeat (2) tick();
      send(16'd2);
      repeat (2) tick();
      send(16'd3);
      repeat (2) tick();
      check("gap_no_early_valid", out_valid, 1'b0);
      exp_q.push_back(mk(10, 4, 1));
      send(16'd4);
      check("gap_latency_valid", out_valid, 1'b1);
      tick();

      // Reset mid-window discards the partial sum.
      send(16'd7);
      send(16'd9);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_sum_cleared", sum_out, 0);
      check("rst_mid_in_ready", in_ready, 1'b1);
      send(16'd1);
      send(16'd2);
      send(16'd3);
      exp_q.push_back(mk(10, 4, 1));
      send(16'd4);
      tick();

      // Reset while DONE discards the pending result.
      out_ready = 1'b0;
      send(16'd100);
      send(16'd200);
      send(16'd300);
      send(16'd400);
      check("rst_done_pending", out_valid, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      check("rst_done_out_valid", out_valid, 1'b0);
      check("rst_done_in_ready", in_ready, 1'b1);
      check("rst_done_sum", sum_out, 0);

      // First sample is the maximum; extremes in the middle.
      send(16'd9);
      send(16'd2);
      send(16'd5);
      exp_q.push_back(mk(23, 9, 2));
      send(16'd7);
      tick();
      send(16'd500);
      send(16'd3);
      send(16'd40000);
      exp_q.push_back(mk(40506, 40000, 3));
      send(16'd3);
      repeat (3) tick();

      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
